serial_link_pkt: RTL
====================

Name: serial_link_pkt

Overview:
Parametrised 2-line serial transmitter/receiver pair on a single clock. The transmitter frames a DATA_W-bit word as start, data (MSB first), optional parity and stop bits. It drives the frame on SDout alongside a divided serial clock SCout. The receiver recovers frames from SCin/SDin, reports the word with a one-cycle PDready strobe, and flags parity and framing errors.

Parameters:
DATA_W, 8, payload width in bits (2..32)
CLK_DIV, 2, Clk cycles per SCout half-period (>=1); bit period = 2*CLK_DIV cycles
PARITY_EN, 1, 1 = parity bit sent and checked; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity (bit = XOR of data); 1 = odd (inverted XOR)

Ports:
Clk  input  1  single system clock, all logic on rising edge
Rst  input  1  synchronous, active-high reset
Send  input  1  transmit request, rising-edge sensitive
PDin  input  DATA_W  parallel word, captured on accepted Send edge
Busy  output  1  transmitter occupied; Send edges ignored while high
SCout  output  1  serial clock, free-running square wave
SDout  output  1  serial data, idles 0
SCin  input  1  serial clock in (same Clk domain)
SDin  input  1  serial data in
PDout  output  DATA_W  last received word, held until next frame completes
PDready  output  1  one-cycle strobe, PDout/ParErr/FrmErr valid
ParErr  output  1  parity mismatch on last frame (always 0 if PARITY_EN=0)
FrmErr  output  1  stop bit of last frame was 1

Behaviour:
- Reset (Rst=1 at a Clk edge): SCout=0, SDout=0, Busy=0, PDout=0, PDready=0, ParErr=0, FrmErr=0; divider, shift registers, bit counters and Send/SCin history registers cleared; both FSMs go to IDLE. Reset mid-frame aborts both sides; no PDready for the aborted frame.
- Divider: counter 0..CLK_DIV-1. SCout toggles at terminal count. "Fall tick" = the cycle in which SCout is toggled 1->0.
- Frame: start bit 1, DATA_W data bits MSB first, parity bit if PARITY_EN, stop bit 0. FRAME_LEN = DATA_W + PARITY_EN + 2.
- Send edge: Send & ~Send_d. It is accepted only if Busy=0 in that cycle. Accepting it latches PDin and computes parity, and Busy goes 1 on the next cycle. Send held high yields exactly one frame. Edges while Busy=1 are dropped, not queued.
- TX FSM, IDLE -> ARM -> SHIFT -> STOP -> IDLE:
  - ARM waits for the next fall tick, then launches the start bit.
  - SHIFT changes SDout once per fall tick, one bit each, for data then parity.
  - STOP drives 0 for one full bit period. Busy clears at the fall tick ending the stop bit, then the FSM returns to IDLE.
  - Start bit is launched within 2*CLK_DIV cycles of acceptance.
- RX sampling: SCin_d register; sample SDin on cycles where SCin & ~SCin_d (rising edge).
- RX FSM, IDLE -> DATA -> PAR -> STOP -> IDLE; PAR is skipped when PARITY_EN=0:
  - IDLE: a sampled 1 is a start bit; a sampled 0 keeps IDLE.
  - DATA: shift in DATA_W samples MSB first.
  - PAR: capture one sample.
  - STOP: capture one sample, then return to IDLE.
- Frame completion, registered on the cycle after the stop sample:
  - PDout <= shifted word; PDready=1 for exactly one cycle.
  - ParErr <= received parity != expected.
  - FrmErr <= stop sample.
  - PDout is updated even when an error is flagged.
  - Error flags hold until the next completion or reset.
- Loopback (SCout->SCin, SDout->SDin): PDready fires CLK_DIV+2 cycles (+-1) after stop-bit launch. Back-to-back frames: a new Send accepted the cycle after Busy falls produces the next start bit at the following fall tick, with no extra idle bit required.
- Width rules: parity is the XOR over exactly DATA_W bits. The bit counter is sized clog2(FRAME_LEN) and must not wrap within a frame.

Test Plan:
- Loopback, DATA_W=8, CLK_DIV=2, even parity: Send rise with PDin=8'hA5 -> SDout bits 1,1010_0101,0,0. PDready pulses once; PDout=8'hA5, ParErr=0, FrmErr=0.
- Same config, PDin=8'h01 -> parity bit 1 on the line; PDout=8'h01, ParErr=0. Rebuild with PARITY_ODD=1 -> parity bit 0 on the line, ParErr=0.
- Bench-driven SDin carrying 8'h3C with the parity bit flipped -> PDout=8'h3C, ParErr=1, FrmErr=0. Next clean frame clears ParErr.
- Bench-driven frame with stop bit 1 -> FrmErr=1, PDready pulse. Send held high 100 cycles -> exactly one frame. Second Send edge while Busy=1 -> no second frame.
- Assert Rst for 1 cycle mid-data-bit -> next cycle SDout=0, Busy=0, SCout=0. No PDready. A following 8'h5A frame is received correctly.
- DATA_W=12, PARITY_EN=0, CLK_DIV=1, two back-to-back Sends 12'hABC then 12'h123 -> two PDready pulses with those values in order, ParErr=0 both.

Source files
------------

// File: rtl/serial_link_pkt_if.sv
// rtl/serial_link_pkt_if.sv - parallel and serial signal bundle for serial_link_pkt
interface serial_link_pkt_if #(
  parameter int DATA_W = 8
);
  logic              Send;
  logic [DATA_W-1:0] PDin;
  logic              Busy;
  logic              SCout;
  logic              SDout;
  logic              SCin;
  logic              SDin;
  logic [DATA_W-1:0] PDout;
  logic              PDready;
  logic              ParErr;
  logic              FrmErr;

  modport master (
    output Send, PDin, SCin, SDin,
    input  Busy, SCout, SDout, PDout, PDready, ParErr, FrmErr
  );

  modport slave (
    input  Send, PDin, SCin, SDin,
    output Busy, SCout, SDout, PDout, PDready, ParErr, FrmErr
  );
endinterface

// File: rtl/serial_link_pkt.sv
// rtl/serial_link_pkt.sv - framed 2-line serial transmitter and receiver on one clock
module serial_link_pkt #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 2,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input logic              Clk,
  input logic              Rst,
  serial_link_pkt_if.slave bus
);
  localparam int   NB        = DATA_W + ((PARITY_EN != 0) ? 1 : 0);
  localparam int   FRAME_LEN = NB + 2;
  localparam int   CW        = $clog2(FRAME_LEN);
  localparam int   DIVW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic ODD       = (PARITY_ODD != 0);

  logic [DIVW-1:0] div_cnt;
  logic            sc_q;
  logic            div_tc;
  logic            fall_tick;

  assign div_tc    = (div_cnt == DIVW'(CLK_DIV - 1));
  assign fall_tick = div_tc & sc_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      div_cnt <= '0;
      sc_q    <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      sc_q    <= ~sc_q;
    end else begin
      div_cnt <= div_cnt + DIVW'(1);
    end
  end

  typedef enum logic [1:0] {TX_IDLE, TX_ARM, TX_SHIFT, TX_STOP} tx_state_t;
  tx_state_t     tx_state, tx_state_n;
  logic          send_d, busy_q, sd_q;
  logic [NB-1:0] tx_sr, tx_load_val;
  logic [CW-1:0] tx_cnt;
  logic          tx_accept, tx_start, tx_bit, tx_stop, tx_end;

  assign tx_accept = bus.Send & ~send_d & ~busy_q;

  // Payload and parity shift out as one word so SHIFT needs no special last bit.
  generate
    if (PARITY_EN != 0) begin : g_tx_par
      assign tx_load_val = {bus.PDin, ^bus.PDin ^ ODD};
    end else begin : g_tx_nopar
      assign tx_load_val = bus.PDin;
    end
  endgenerate

  always_comb begin
    tx_state_n = tx_state;
    tx_start   = 1'b0;
    tx_bit     = 1'b0;
    tx_stop    = 1'b0;
    tx_end     = 1'b0;
    case (tx_state)
      TX_IDLE:  if (tx_accept) tx_state_n = TX_ARM;
      TX_ARM:   if (fall_tick) begin
                  tx_start   = 1'b1;
                  tx_state_n = TX_SHIFT;
                end
      TX_SHIFT: if (fall_tick) begin
                  if (tx_cnt == CW'(NB)) begin
                    tx_stop    = 1'b1;
                    tx_state_n = TX_STOP;
                  end else begin
                    tx_bit = 1'b1;
                  end
                end
      TX_STOP:  if (fall_tick) begin
                  tx_end     = 1'b1;
                  tx_state_n = TX_IDLE;
                end
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tx_state <= TX_IDLE;
      send_d   <= 1'b0;
      busy_q   <= 1'b0;
      sd_q     <= 1'b0;
      tx_sr    <= '0;
      tx_cnt   <= '0;
    end else begin
      tx_state <= tx_state_n;
      send_d   <= bus.Send;
      if (tx_accept) begin
        busy_q <= 1'b1;
        tx_sr  <= tx_load_val;
      end
      if (tx_start) begin
        sd_q   <= 1'b1;
        tx_cnt <= '0;
      end
      if (tx_bit) begin
        sd_q   <= tx_sr[NB-1];
        tx_sr  <= tx_sr << 1;
        tx_cnt <= tx_cnt + CW'(1);
      end
      if (tx_stop) sd_q <= 1'b0;
      if (tx_end) busy_q <= 1'b0;
    end
  end

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  rx_state_t         rx_state, rx_state_n;
  logic              sc_in_d, rx_smp, rx_par;
  logic              rx_first, rx_shift, rx_capt_par, rx_done;
  logic [DATA_W-1:0] rx_sr, pd_q;
  logic [CW-1:0]     rx_cnt;
  logic              pdr_q, perr_q, ferr_q;

  assign rx_smp = bus.SCin & ~sc_in_d;

  always_comb begin
    rx_state_n  = rx_state;
    rx_first    = 1'b0;
    rx_shift    = 1'b0;
    rx_capt_par = 1'b0;
    rx_done     = 1'b0;
    if (rx_smp) begin
      case (rx_state)
        RX_IDLE: if (bus.SDin) begin
                   rx_first   = 1'b1;
                   rx_state_n = RX_DATA;
                 end
        RX_DATA: begin
                   rx_shift = 1'b1;
                   if (rx_cnt == CW'(DATA_W - 1))
                     rx_state_n = (PARITY_EN != 0) ? RX_PAR : RX_STOP;
                 end
        RX_PAR:  begin
                   rx_capt_par = 1'b1;
                   rx_state_n  = RX_STOP;
                 end
        RX_STOP: begin
                   rx_done    = 1'b1;
                   rx_state_n = RX_IDLE;
                 end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_state <= RX_IDLE;
      sc_in_d  <= 1'b0;
      rx_sr    <= '0;
      rx_cnt   <= '0;
      rx_par   <= 1'b0;
      pd_q     <= '0;
      pdr_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      sc_in_d  <= bus.SCin;
      pdr_q    <= 1'b0;
      if (rx_first) rx_cnt <= '0;
      if (rx_shift) begin
        rx_sr  <= {rx_sr[DATA_W-2:0], bus.SDin};
        rx_cnt <= rx_cnt + CW'(1);
      end
      if (rx_capt_par) rx_par <= bus.SDin;
      // The stop sample itself is the framing error: a healthy stop bit is 0.
      if (rx_done) begin
        pd_q   <= rx_sr;
        pdr_q  <= 1'b1;
        ferr_q <= bus.SDin;
        perr_q <= (PARITY_EN != 0) && (rx_par != (^rx_sr ^ ODD));
      end
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.SCout   = sc_q;
  assign bus.SDout   = sd_q;
  assign bus.PDout   = pd_q;
  assign bus.PDready = pdr_q;
  assign bus.ParErr  = perr_q;
  assign bus.FrmErr  = ferr_q;
endmodule
